spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_spi_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter and the external byte engine.
//   - spi_state_e : arbiter FSM state encoding
//   - DEF_*       : default parameter values for NUM_REQ, LEN_W, CS_SETUP,
//                   CS_HOLD and TIMEOUT
//   - max3        : elaboration-time helper for sizing counters
package spi_pkg;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_CS_SETUP = 4;
  localparam int DEF_CS_HOLD  = 4;
  localparam int DEF_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   last_ptr : index granted most recently; the search starts just after it
//   grant    : one-hot grant (all zeros when no request is pending)
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Visit last_ptr+1, last_ptr+2, ... wrapping; last_ptr itself comes last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI byte engine between NUM_REQ requesters, one burst at a time.
//   req/req_len/tx_data     : per-requester request, length-1, next tx byte
//   gnt/tx_ack              : one-hot grant for the burst, byte-consumed pulse
//   rx_data/rx_valid        : received byte and its one-cycle strobe
//   burst_done/burst_err    : end-of-burst pulse (normal / timed out)
//   cs_n                    : per-device chip select, active low
//   eng_start/eng_data      : byte engine start pulse and byte to send
//   eng_done/eng_rdata      : byte engine completion pulse and received byte
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     tx_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     tx_ack,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic                     burst_done,
  output logic                     burst_err,
  output logic [NUM_REQ-1:0]       cs_n,
  output logic                     eng_start,
  output logic [7:0]               eng_data,
  input  logic                     eng_done,
  input  logic [7:0]               eng_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(max3(TIMEOUT, CS_SETUP, CS_HOLD) + 1);

  // SETUP counts 0..CS_SETUP-1. HOLD is entered with the counter at 1 (the
  // completing cycle already counts), so cs_n rises CS_HOLD cycles after the
  // last eng_done or the timeout cycle.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP > 1) ? CS_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD > 2) ? CS_HOLD - 1 : 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(NUM_REQ - 1);

  spi_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   bcnt, bcnt_nxt;
  logic               abort, abort_nxt;
  logic [IDX_W-1:0]   sel, last_ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               take_grant, hold_exit;

  logic [NUM_REQ-1:0] gnt_nxt;
  logic               eng_start_nxt, tx_ack_nxt, rx_valid_nxt;
  logic               burst_done_nxt, burst_err_nxt;
  logic [7:0]         eng_data_nxt, rx_data_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req      (req),
    .last_ptr (last_ptr),
    .grant    (grant_oh)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_idx = IDX_W'(i);
    end
  end

  assign take_grant = (state == ST_IDLE) && (|req);
  assign hold_exit  = (state == ST_HOLD) && (cnt == HOLD_LAST);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      abort      <= 1'b0;
      sel        <= '0;
      last_ptr   <= PTR_RST;
      gnt        <= '0;
      cs_n       <= '1;
      eng_start  <= 1'b0;
      eng_data   <= '0;
      tx_ack     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bcnt       <= bcnt_nxt;
      abort      <= abort_nxt;
      if (take_grant) begin
        sel      <= grant_idx;
        last_ptr <= grant_idx;
      end
      gnt        <= gnt_nxt;
      cs_n       <= ~gnt_nxt;
      eng_start  <= eng_start_nxt;
      eng_data   <= eng_data_nxt;
      tx_ack     <= tx_ack_nxt;
      rx_valid   <= rx_valid_nxt;
      rx_data    <= rx_data_nxt;
      burst_done <= burst_done_nxt;
      burst_err  <= burst_err_nxt;
    end
  end

  // Next state and counters. cnt is SETUP/HOLD dwell time, and in SEND/WAIT
  // the cycles elapsed since the current eng_start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bcnt_nxt  = bcnt;
    abort_nxt = abort;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (take_grant) begin
          state_nxt = ST_SETUP;
          bcnt_nxt  = req_len[grant_idx*LEN_W +: LEN_W];
          abort_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = ST_SEND;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_WAIT: begin
        if (eng_done) begin
          if (bcnt == '0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = ST_SEND;
            cnt_nxt   = '0;
            bcnt_nxt  = bcnt - LEN_W'(1);
          end
        end else if (cnt == TO_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(1);
          abort_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (hold_exit) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values loaded into the output registers at the next edge
  always_comb begin
    gnt_nxt = gnt;
    if (take_grant)     gnt_nxt = grant_oh;
    else if (hold_exit) gnt_nxt = '0;

    // eng_data is captured on the edge entering SEND, so tx_data is sampled
    // at least one cycle after the previous tx_ack.
    eng_start_nxt = (state_nxt == ST_SEND);
    tx_ack_nxt    = (state_nxt == ST_SEND);
    eng_data_nxt  = eng_data;
    if (state_nxt == ST_SEND) eng_data_nxt = tx_data[sel*8 +: 8];

    rx_valid_nxt = (state == ST_WAIT) && eng_done;
    rx_data_nxt  = rx_data;
    if (rx_valid_nxt) rx_data_nxt = eng_rdata;

    burst_done_nxt = hold_exit && !abort;
    burst_err_nxt  = hold_exit && abort;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter with a 3-cycle echo-inverse byte engine.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req = 2'b00;
  logic [7:0]  req_len = 8'h00;
  logic [15:0] tx_data = 16'h0000;
  logic [1:0]  gnt, cs_n;
  logic        tx_ack, rx_valid, burst_done, burst_err, eng_start;
  logic [7:0]  rx_data, eng_data;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_rdata = 8'h00;
  logic        eng_mute = 1'b0;
  logic [7:0]  bytes0 [16];
  logic [7:0]  bytes1 [16];

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor-owned observation state
  int  cyc = 0, n_start = 0, n_done = 0, n_err = 0;
  int  n_map_bad = 0, n_overlap = 0, n_start_bad = 0;
  int  t_csfall = 0, t_first_start = 0, t_done = 0, t_csrise = 0;
  int  cd = 0;
  bit  first_pending = 1'b0, inflight = 1'b0, prev_cs_low = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  logic [3:0] burst_ack = 4'd0;
  logic [7:0] rxq [$];
  logic [7:0] edq [$];
  int  glog [$];

  spi_arbiter #(
    .NUM_REQ(2), .LEN_W(4), .CS_SETUP(4), .CS_HOLD(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .tx_data(tx_data),
    .gnt(gnt), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .burst_done(burst_done), .burst_err(burst_err), .cs_n(cs_n),
    .eng_start(eng_start), .eng_data(eng_data), .eng_done(eng_done),
    .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  // Observe DUT outputs mid-cycle, then act as byte engine and requesters.
  always @(negedge clk) begin
    bit cs_low;
    cyc++;
    cs_low = (cs_n != 2'b11);
    if (cs_n != ~gnt) n_map_bad++;
    if (cs_n == 2'b00) n_overlap++;
    if (cs_low && !prev_cs_low) begin
      t_csfall = cyc; first_pending = 1'b1; burst_ack = 4'd0;
    end
    if (!cs_low && prev_cs_low) begin
      t_csrise = cyc; inflight = 1'b0;
    end
    prev_cs_low = cs_low;
    for (int r = 0; r < 2; r++) if (gnt[r] && !prev_gnt[r]) glog.push_back(r);
    prev_gnt = gnt;
    if (eng_start) begin
      n_start++;
      edq.push_back(eng_data);
      if (inflight) n_start_bad++;
      inflight = 1'b1;
      if (first_pending) begin t_first_start = cyc; first_pending = 1'b0; end
    end
    if (tx_ack) burst_ack = burst_ack + 4'd1;
    if (rx_valid) rxq.push_back(rx_data);
    if (burst_done) n_done++;
    if (burst_err) n_err++;

    eng_done = 1'b0;
    if (!rst_n) begin
      cd = 0; inflight = 1'b0; first_pending = 1'b0;
    end else if (eng_start) begin
      cd = 3;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && !eng_mute) begin
        eng_done = 1'b1; eng_rdata = ~eng_data; t_done = cyc; inflight = 1'b0;
      end
    end
    tx_data = {bytes1[gnt[1] ? burst_ack : 4'd0], bytes0[gnt[0] ? burst_ack : 4'd0]};
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic request(input int r, input logic [3:0] len, output bit ok);
    ok = 1'b0;
    req_len[r*4 +: 4] = len;
    req[r] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (gnt[r]) ok = 1'b1;
    end
    req[r] = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (n_done + n_err >= target) ok = 1'b1;
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_tests++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 11", cs_n); end
    n_tests++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start: got %b expected 0", eng_start); end
    n_tests++; if (eng_data !== 8'h00) begin n_fail++; $display("FAIL reset_eng_data: got %h expected 00", eng_data); end
    n_tests++; if (tx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ack: got %b expected 0", tx_ack); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_tests++; if (burst_done !== 1'b0 || burst_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", burst_done, burst_err); end
    tick(3);
    rst_n = 1'b1;
    tick(3);
    n_tests++; if (gnt !== 2'b00 || cs_n !== 2'b11)
      begin n_fail++; $display("FAIL idle_after_reset: got gnt=%b cs_n=%b expected 00/11", gnt, cs_n); end
  endtask

  task automatic test_contention();
    int gb, db, ob, mb;
    bit ok;
    int exp_g [3] = '{0, 1, 0};
    do_reset();
    for (int i = 0; i < 16; i++) begin bytes0[i] = 8'h10 + 8'(i); bytes1[i] = 8'h20 + 8'(i); end
    req_len = 8'h00;
    gb = glog.size(); db = n_done; ob = n_overlap; mb = n_map_bad;
    req = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      if (glog.size() - gb >= 3) ok = 1'b1;
    end
    req = 2'b00;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL contention_grants: got %0d grants expected 3", glog.size() - gb); end
    wait_bursts(n_done + n_err + 1, 200, ok);
    n_tests++; if (n_done - db != 3) begin n_fail++; $display("FAIL contention_done: got %0d expected 3", n_done - db); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (glog.size() <= gb + k || glog[gb+k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL contention_order%0d: got %0d expected %0d", k,
                 (glog.size() > gb + k) ? glog[gb+k] : -1, exp_g[k]);
      end
    end
    n_tests++; if (n_overlap != ob || n_map_bad != mb)
      begin n_fail++; $display("FAIL contention_cs_excl: got %0d overlap/%0d map cycles expected 0", n_overlap - ob, n_map_bad - mb); end
  endtask

  task automatic test_single();
    int sb, rb, eb, db, erb, bb, mb;
    bit ok;
    logic [7:0] exp_tx [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] exp_rx [3] = '{8'h5A, 8'hC3, 8'h00};
    for (int i = 0; i < 3; i++) bytes0[i] = exp_tx[i];
    sb = n_start; rb = rxq.size(); eb = edq.size(); db = n_done; erb = n_err; bb = n_start_bad; mb = n_map_bad;
    request(0, 4'd2, ok);
    n_tests++; if (!ok || gnt !== 2'b01 || cs_n !== 2'b10)
      begin n_fail++; $display("FAIL single_grant: got gnt=%b cs_n=%b expected 01/10", gnt, cs_n); end
    wait_bursts(db + erb + 1, 200, ok);
    n_tests++; if (n_start - sb != 3) begin n_fail++; $display("FAIL single_starts: got %0d expected 3", n_start - sb); end
    n_tests++; if (n_start_bad != bb) begin n_fail++; $display("FAIL single_start_spacing: got %0d early starts expected 0", n_start_bad - bb); end
    n_tests++; if (rxq.size() - rb != 3) begin n_fail++; $display("FAIL single_rx_count: got %0d expected 3", rxq.size() - rb); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (edq.size() <= eb + k || edq[eb+k] !== exp_tx[k])
        begin n_fail++; $display("FAIL single_eng_data%0d: got %h expected %h", k, (edq.size() > eb + k) ? edq[eb+k] : 8'hxx, exp_tx[k]); end
      n_tests++;
      if (rxq.size() <= rb + k || rxq[rb+k] !== exp_rx[k])
        begin n_fail++; $display("FAIL single_rx%0d: got %h expected %h", k, (rxq.size() > rb + k) ? rxq[rb+k] : 8'hxx, exp_rx[k]); end
    end
    n_tests++; if (n_done - db != 1 || n_err != erb)
      begin n_fail++; $display("FAIL single_done: got done=%0d err=%0d expected 1/0", n_done - db, n_err - erb); end
    n_tests++; if (n_map_bad != mb) begin n_fail++; $display("FAIL single_cs_held: got %0d bad cycles expected 0", n_map_bad - mb); end
  endtask

  task automatic test_setup_hold();
    int db;
    bit ok;
    bytes1[0] = 8'h81; bytes1[1] = 8'h42;
    db = n_done + n_err;
    request(1, 4'd1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sh_grant: got gnt=%b expected 10", gnt); end
    wait_bursts(db + 1, 200, ok);
    n_tests++; if (t_first_start - t_csfall != 4)
      begin n_fail++; $display("FAIL cs_setup: got %0d cycles expected 4", t_first_start - t_csfall); end
    n_tests++; if (t_csrise - t_done != 4)
      begin n_fail++; $display("FAIL cs_hold: got %0d cycles expected 4", t_csrise - t_done); end
  endtask

  task automatic test_len_min();
    int sb, rb, db;
    bit ok;
    bytes0[0] = 8'h96;
    sb = n_start; rb = rxq.size(); db = n_done;
    request(0, 4'd0, ok);
    wait_bursts(n_done + n_err + 1, 200, ok);
    n_tests++; if (n_start - sb != 1) begin n_fail++; $display("FAIL len0_starts: got %0d expected 1", n_start - sb); end
    n_tests++; if (rxq.size() - rb != 1 || rxq[rb] !== 8'h69)
      begin n_fail++; $display("FAIL len0_rx: got %0d bytes expected 1 byte 69", rxq.size() - rb); end
    n_tests++; if (n_done - db != 1) begin n_fail++; $display("FAIL len0_done: got %0d expected 1", n_done - db); end
  endtask

  task automatic test_len_max();
    int sb, rb, db, bad;
    bit ok;
    for (int i = 0; i < 16; i++) bytes1[i] = 8'(i * 17);
    sb = n_start; rb = rxq.size(); db = n_done;
    request(1, 4'd15, ok);
    wait_bursts(n_done + n_err + 1, 600, ok);
    n_tests++; if (n_start - sb != 16) begin n_fail++; $display("FAIL len15_starts: got %0d expected 16", n_start - sb); end
    n_tests++; if (rxq.size() - rb != 16) begin n_fail++; $display("FAIL len15_rx_count: got %0d expected 16", rxq.size() - rb); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (rxq.size() <= rb + i || rxq[rb+i] !== ~8'(i * 17)) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL len15_rx_data: got %0d wrong bytes expected 0", bad); end
    n_tests++; if (n_done - db != 1) begin n_fail++; $display("FAIL len15_done: got %0d expected 1", n_done - db); end
  endtask

  task automatic test_timeout();
    int sb, rb, db, erb;
    bit ok;
    eng_mute = 1'b1;
    bytes0[0] = 8'h11;
    sb = n_start; rb = rxq.size(); db = n_done; erb = n_err;
    request(0, 4'd2, ok);
    wait_bursts(db + erb + 1, 200, ok);
    eng_mute = 1'b0;
    n_tests++; if (t_csrise - t_first_start != 19)
      begin n_fail++; $display("FAIL timeout_cs_rise: got %0d cycles expected 19", t_csrise - t_first_start); end
    n_tests++; if (n_err - erb != 1 || n_done != db)
      begin n_fail++; $display("FAIL timeout_err: got err=%0d done=%0d expected 1/0", n_err - erb, n_done - db); end
    n_tests++; if (rxq.size() != rb) begin n_fail++; $display("FAIL timeout_rx: got %0d bytes expected 0", rxq.size() - rb); end
    n_tests++; if (n_start - sb != 1) begin n_fail++; $display("FAIL timeout_starts: got %0d expected 1", n_start - sb); end
  endtask

  task automatic test_reset_mid();
    int sb, db, erb;
    bit ok;
    for (int i = 0; i < 4; i++) bytes0[i] = 8'hC0 + 8'(i);
    sb = n_start;
    request(0, 4'd3, ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (n_start - sb >= 2) ok = 1'b1;
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_wait: got %0d starts expected 2", n_start - sb); end
    db = n_done; erb = n_err;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (cs_n !== 2'b11 || gnt !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_release: got cs_n=%b gnt=%b expected 11/00", cs_n, gnt); end
    tick(2);
    rst_n = 1'b1;
    tick(10);
    n_tests++; if (n_done != db || n_err != erb)
      begin n_fail++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0/0", n_done - db, n_err - erb); end
    n_tests++; if (cs_n !== 2'b11 || gnt !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_idle: got cs_n=%b gnt=%b expected 11/00", cs_n, gnt); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin bytes0[i] = 8'h00; bytes1[i] = 8'h00; end
    test_reset();
    test_contention();
    test_single();
    test_setup_hold();
    test_len_min();
    test_len_max();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
